// File: rtl/mystic_fetch_unit.sv
// Instruction-fetch responder: returns one 16- or 32-bit instruction per PC strobe,
// stitching word-crossing instructions and reusing a one-entry fetched-word buffer.
module mystic_fetch_unit #(
    parameter int BUF_EN = 1,
    parameter int MEM_AW = 30
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       PC_i,
    input  logic              PC_read_i,
    input  logic              inval_i,
    output logic [31:0]       instr_o,
    output logic              is_compressed_o,
    output logic              instr_ready_o,
    output logic              mem_req_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_rvalid_i
);

    typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_t;

    localparam logic [MEM_AW-1:0] WORD_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              pc1_q, pc1_d;
    logic [MEM_AW-1:0] word_q, word_d;
    logic [15:0]       hi_q, hi_d;
    logic              buf_valid_q, buf_valid_d;
    logic [MEM_AW-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic [31:0]       instr_q, instr_d;
    logic              is_c_q, is_c_d;
    logic              ready_q, ready_d;
    logic              req_q, req_d;
    logic [MEM_AW-1:0] addr_q, addr_d;

    logic [MEM_AW-1:0] pc_word;
    logic              buf_hit;
    logic [33:0]       ext;
    logic              unused_ok;

    assign pc_word   = PC_i[MEM_AW+1:2];
    assign unused_ok = PC_i[0];
    assign buf_hit   = (BUF_EN != 0) && buf_valid_q && !inval_i && (buf_addr_q == pc_word);

    // Result is {needs_next_word, is_compressed, instr}; hi selects the upper halfword.
    function automatic logic [33:0] extract(input logic [31:0] w, input logic hi);
        logic [15:0] half;
        half = hi ? w[31:16] : w[15:0];
        if (half[1:0] != 2'b11)
            return {1'b0, 1'b1, 16'h0000, half};
        else if (!hi)
            return {1'b0, 1'b0, w};
        else
            return {1'b1, 1'b0, 32'h0000_0000};
    endfunction

    always_comb begin
        state_d     = state_q;
        pc1_d       = pc1_q;
        word_d      = word_q;
        hi_d        = hi_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        instr_d     = instr_q;
        is_c_d      = is_c_q;
        ready_d     = 1'b0;
        req_d       = 1'b0;
        addr_d      = addr_q;
        ext         = '0;

        case (state_q)
            IDLE: begin
                if (PC_read_i) begin
                    pc1_d  = PC_i[1];
                    word_d = pc_word;
                    if (buf_hit) begin
                        ext = extract(buf_data_q, PC_i[1]);
                        if (ext[33]) begin
                            hi_d    = buf_data_q[31:16];
                            req_d   = 1'b1;
                            addr_d  = pc_word + WORD_ONE;
                            state_d = WAIT_HI;
                        end else begin
                            instr_d = ext[31:0];
                            is_c_d  = ext[32];
                            ready_d = 1'b1;
                        end
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = pc_word;
                        state_d = WAIT_LO;
                    end
                end
            end
            WAIT_LO: begin
                if (mem_rvalid_i) begin
                    buf_valid_d = (BUF_EN != 0);
                    buf_addr_d  = word_q;
                    buf_data_d  = mem_rdata_i;
                    ext         = extract(mem_rdata_i, pc1_q);
                    if (ext[33]) begin
                        hi_d    = mem_rdata_i[31:16];
                        req_d   = 1'b1;
                        addr_d  = word_q + WORD_ONE;
                        state_d = WAIT_HI;
                    end else begin
                        instr_d = ext[31:0];
                        is_c_d  = ext[32];
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HI: begin
                if (mem_rvalid_i) begin
                    buf_valid_d = (BUF_EN != 0);
                    buf_addr_d  = addr_q;
                    buf_data_d  = mem_rdata_i;
                    instr_d     = {mem_rdata_i[15:0], hi_q};
                    is_c_d      = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Invalidation overrides any load in the same cycle; an in-flight fetch still finishes.
        if (inval_i)
            buf_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc1_q       <= 1'b0;
            word_q      <= '0;
            hi_q        <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            instr_q     <= '0;
            is_c_q      <= 1'b0;
            ready_q     <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc1_q       <= pc1_d;
            word_q      <= word_d;
            hi_q        <= hi_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            instr_q     <= instr_d;
            is_c_q      <= is_c_d;
            ready_q     <= ready_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
        end
    end

    assign instr_o         = instr_q;
    assign is_compressed_o = is_c_q;
    assign instr_ready_o   = ready_q;
    assign mem_req_o       = req_q;
    assign mem_addr_o      = addr_q;

endmodule
